// File: rtl/fetch_sequencer_pkg.sv
// fetch_seq_pkg: shared state and PC-select encodings for the fetch sequencer.
package fetch_seq_pkg;
   typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN, S_ERR} fetch_state_t;
   typedef enum logic [1:0] {PC_SEQ = 2'd0, PC_BR = 2'd1, PC_EXT = 2'd2} pc_sel_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: hazard/branch/memory handshake bundle between the sequencer and the IF datapath.
interface fetch_sequencer_if;
   import fetch_seq_pkg::*;
   logic    imem_ready;
   logic    hz_stall;
   logic    br_resolve;
   logic    br_taken;
   logic    br_uncond;
   logic    pc_ext_req;
   logic    pc_we;
   pc_sel_t pc_sel;
   logic    uncond_sel;
   logic    imem_req;
   logic    ifid_we;
   logic    ifid_flush;
   logic    idex_bubble;
   logic    fetch_err;
   modport master (
      input  imem_ready, hz_stall, br_resolve, br_taken, br_uncond, pc_ext_req,
      output pc_we, pc_sel, uncond_sel, imem_req, ifid_we, ifid_flush, idex_bubble, fetch_err
   );
   modport slave (
      output imem_ready, hz_stall, br_resolve, br_taken, br_uncond, pc_ext_req,
      input  pc_we, pc_sel, uncond_sel, imem_req, ifid_we, ifid_flush, idex_bubble, fetch_err
   );
endinterface

// File: rtl/fetch_sequencer_event_counter.sv
// event_counter: wrapping up-counter with synchronous active-low reset and synchronous clear.
module event_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);
   always_ff @(posedge clk)
      if (!reset || clear) count <= '0;
      else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage control (PC select/enable, IMEM handshake, flush/bubble, timeout).
// Optional perf counters enabled with macro FETCH_PERF_EN.
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int BOOT_CYCLES = 4,
   parameter int TIMEOUT     = 16
`ifdef FETCH_PERF_EN
   ,
   parameter int PERF_W      = 32
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef FETCH_PERF_EN
   output logic [PERF_W-1:0]    perf_fetch,
   output logic [PERF_W-1:0]    perf_redirect,
   output logic [PERF_W-1:0]    perf_stall,
`endif
   fetch_sequencer_if.master    bus
);
   localparam int BW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
   localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

   fetch_state_t    state, nxt;
   logic [WW-1:0]   wait_cnt, wait_nxt;
   logic [BW-1:0]   boot_cnt;
   logic            boot_done, redirect;
   logic            pc_we, uncond_sel, imem_req, ifid_we, ifid_flush, idex_bubble, fetch_err;
   pc_sel_t         pc_sel;

   event_counter #(.W(BW)) u_boot (
      .clk(clk), .reset(reset), .inc(state == S_BOOT), .clear(state != S_BOOT), .count(boot_cnt)
   );

   assign boot_done = (BOOT_CYCLES <= 1) || (boot_cnt == BW'(BOOT_CYCLES - 1));
   assign redirect  = bus.br_resolve && bus.br_taken;

   always_ff @(posedge clk)
      if (!reset) begin
         state    <= S_BOOT;
         wait_cnt <= '0;
      end else begin
         state    <= nxt;
         wait_cnt <= wait_nxt;
      end

   // Outputs are forced low whenever reset is asserted, regardless of the registered state.
   always_comb begin
      nxt         = state;
      wait_nxt    = wait_cnt;
      pc_we       = 1'b0;
      pc_sel      = PC_SEQ;
      uncond_sel  = 1'b0;
      imem_req    = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      fetch_err   = 1'b0;
      if (reset)
         case (state)
            S_BOOT: nxt = boot_done ? S_RUN : S_BOOT;
            S_RUN: begin
               imem_req = 1'b1;
               ifid_we  = 1'b1;
               if (bus.pc_ext_req) begin
                  pc_we      = 1'b1;
                  pc_sel     = PC_EXT;
                  ifid_flush = 1'b1;
               end else if (redirect) begin
                  pc_we       = 1'b1;
                  pc_sel      = PC_BR;
                  uncond_sel  = bus.br_uncond;
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (bus.hz_stall) begin
                  ifid_we     = 1'b0;
                  idex_bubble = 1'b1;
               end else if (bus.imem_ready) pc_we = 1'b1;
               else begin
                  ifid_flush = 1'b1;
                  wait_nxt   = wait_cnt + 1'b1;
                  nxt        = (wait_cnt == WW'(TIMEOUT - 1)) ? S_ERR : S_RUN;
               end
               // A redirect with a fetch still in flight must throw that word away first.
               if ((bus.pc_ext_req || redirect) && !bus.imem_ready) nxt = S_DRAIN;
               if (bus.imem_ready || nxt != S_RUN) wait_nxt = '0;
            end
            S_DRAIN: begin
               ifid_we    = 1'b1;
               ifid_flush = 1'b1;
               pc_we      = bus.pc_ext_req;
               pc_sel     = bus.pc_ext_req ? PC_EXT : PC_SEQ;
               nxt        = bus.imem_ready ? S_RUN : S_DRAIN;
            end
            default: fetch_err = 1'b1;
         endcase
   end

   assign bus.pc_we       = pc_we;
   assign bus.pc_sel      = pc_sel;
   assign bus.uncond_sel  = uncond_sel;
   assign bus.imem_req    = imem_req;
   assign bus.ifid_we     = ifid_we;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign bus.fetch_err   = fetch_err;

`ifdef FETCH_PERF_EN
   event_counter #(.W(PERF_W)) u_perf_fetch (
      .clk(clk), .reset(reset), .inc(state == S_RUN && pc_we && pc_sel == PC_SEQ),
      .clear(1'b0), .count(perf_fetch)
   );
   event_counter #(.W(PERF_W)) u_perf_redirect (
      .clk(clk), .reset(reset), .inc(pc_we && pc_sel != PC_SEQ),
      .clear(1'b0), .count(perf_redirect)
   );
   // Only a winning hz_stall produces a bubble without a PC write in S_RUN.
   event_counter #(.W(PERF_W)) u_perf_stall (
      .clk(clk), .reset(reset), .inc(state == S_RUN && idex_bubble && !pc_we),
      .clear(1'b0), .count(perf_stall)
   );
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer (default parameters).
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [8:0] outs;

   fetch_sequencer_if bus();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch, perf_redirect, perf_stall;
   fetch_sequencer dut (
      .clk(clk), .reset(reset), .perf_fetch(perf_fetch), .perf_redirect(perf_redirect),
      .perf_stall(perf_stall), .bus(bus)
   );
`else
   fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
`endif

   always #5 clk = ~clk;

   assign outs = {bus.fetch_err, bus.idex_bubble, bus.ifid_flush, bus.ifid_we,
                  bus.imem_req, bus.uncond_sel, bus.pc_sel, bus.pc_we};

   function automatic logic [8:0] mk(input logic err, bub, fl, we, req, unc,
                                     input logic [1:0] sel, input logic pwe);
      return {err, bub, fl, we, req, unc, sel, pwe};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic ext, res, tkn, unc, stall, rdy);
      bus.pc_ext_req = ext;
      bus.br_resolve = res;
      bus.br_taken   = tkn;
      bus.br_uncond  = unc;
      bus.hz_stall   = stall;
      bus.imem_ready = rdy;
   endtask

   task automatic cyc(input string tag, input logic [8:0] exp);
      @(negedge clk);
      check(tag, {23'd0, outs}, {23'd0, exp});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] seqf, drn, waito, errf;
      seqf  = mk(0, 0, 0, 1, 1, 0, 2'd0, 1);
      drn   = mk(0, 0, 1, 1, 0, 0, 2'd0, 0);
      waito = mk(0, 0, 1, 1, 1, 0, 2'd0, 0);
      errf  = mk(1, 0, 0, 0, 0, 0, 2'd0, 0);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 2; i++) cyc("rst", 9'd0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) cyc("boot", 9'd0);
      for (int i = 0; i < 3; i++) cyc("seq", seqf);
      drive(0, 1, 1, 1, 0, 1);
      cyc("br_rdy", mk(0, 1, 1, 1, 1, 1, 2'd1, 1));
      drive(0, 0, 0, 0, 0, 1);
      cyc("br_stay", seqf);
      drive(0, 1, 1, 0, 0, 0);
      cyc("br_wait", mk(0, 1, 1, 1, 1, 0, 2'd1, 1));
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) cyc("drain", drn);
      drive(0, 0, 0, 0, 0, 1);
      cyc("drain_rdy", drn);
      cyc("drain_exit", seqf);
      drive(1, 1, 1, 0, 1, 1);
      cyc("prio", mk(0, 0, 1, 1, 1, 0, 2'd2, 1));
      drive(0, 0, 0, 0, 1, 1);
      cyc("stall", mk(0, 1, 0, 0, 1, 0, 2'd0, 0));
      drive(1, 0, 0, 0, 0, 0);
      cyc("ext_wait", mk(0, 0, 1, 1, 1, 0, 2'd2, 1));
      cyc("drain_ext", mk(0, 0, 1, 1, 0, 0, 2'd2, 1));
      drive(0, 1, 1, 1, 0, 0);
      cyc("drain_br", drn);
      drive(0, 0, 0, 0, 0, 1);
      cyc("drain_rdy2", drn);
      cyc("run2", seqf);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) cyc("wait15", waito);
      drive(0, 0, 0, 0, 0, 1);
      cyc("wait_ok", seqf);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc("wait16", waito);
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) cyc("err", errf);
      drive(1, 1, 1, 1, 1, 1);
      for (int i = 0; i < 2; i++) cyc("err_in", errf);
      reset = 1'b0;
      cyc("err_rst", 9'd0);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc("boot2", 9'd0);
      drive(1, 0, 0, 0, 0, 0);
      cyc("ext_wait2", mk(0, 0, 1, 1, 1, 0, 2'd2, 1));
      drive(0, 0, 0, 0, 0, 0);
      cyc("drain3", drn);
      reset = 1'b0;
      cyc("drain_rst", 9'd0);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc("boot3", 9'd0);
      for (int i = 0; i < 10; i++) cyc("seq10", seqf);
      drive(0, 1, 1, 0, 0, 1);
      for (int i = 0; i < 2; i++) cyc("br2", mk(0, 1, 1, 1, 1, 0, 2'd1, 1));
      drive(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cyc("stall3", mk(0, 1, 0, 0, 1, 0, 2'd0, 0));
      drive(0, 0, 0, 0, 0, 0);
`ifdef FETCH_PERF_EN
      @(negedge clk);
      check("perf_fetch", perf_fetch, 32'd10);
      check("perf_redirect", perf_redirect, 32'd2);
      check("perf_stall", perf_stall, 32'd3);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control block for the instruction-fetch stage of the pipelined LEGv8 core.
- Drives the select and write-enable of the 64-bit program counter datapath: sequential +4, branch target, or external load.
- Handshakes with a variable-latency instruction memory and manages IF/ID flush and ID/EX bubble on redirects and stalls.
- Detects fetch timeouts and enters a sticky error state.

Parameters:
- BOOT_CYCLES, 4: idle cycles after reset release before the first fetch request; 0 allowed.
- TIMEOUT, 16: consecutive unanswered fetch cycles in S_RUN that trigger S_ERR; must be ≥1.
- PERF_W, 32: width of the performance counters. Only used with FETCH_PERF_EN.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk, reset asserted when 0.
- imem_ready  in  1  instruction word for the outstanding request is valid this cycle.
- hz_stall  in  1  load-use stall from the hazard unit.
- br_resolve  in  1  branch resolved in EX this cycle.
- br_taken  in  1  resolved branch is taken; qualified by br_resolve.
- br_uncond  in  1  resolved branch uses the 26-bit offset (B/BL); 0 means the 19-bit offset (CBZ/B.cond).
- pc_ext_req  in  1  load the PC from the external/debug value.
- pc_we  out  1  PC register write enable.
- pc_sel  out  2  PC next-value select: 0 = SEQ, 1 = BR, 2 = EXT.
- uncond_sel  out  1  drives the PC datapath UncondBr select.
- imem_req  out  1  fetch request at the current PC.
- ifid_we  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a NOP; only meaningful with ifid_we.
- idex_bubble  out  1  ID/EX loads a bubble.
- fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- Outputs are combinational from state and inputs (Mealy). Latency from an event to PC update is zero; the PC register updates at the same posedge.
- States: S_BOOT, S_RUN, S_DRAIN, S_ERR.
- Reset:
  - State goes to S_BOOT; boot_cnt and wait_cnt go to 0.
  - Every output is 0 while reset=0 and in the first S_BOOT cycle.
- S_BOOT:
  - All outputs 0; boot_cnt increments each cycle.
  - Go to S_RUN when boot_cnt==BOOT_CYCLES-1. With BOOT_CYCLES=0, go to S_RUN on the first cycle after reset.
- S_RUN: imem_req=1. Strict priority, highest first:
  1. pc_ext_req: pc_we=1, pc_sel=EXT, ifid_we=1, ifid_flush=1.
  2. br_resolve&br_taken: pc_we=1, pc_sel=BR, uncond_sel=br_uncond, ifid_we=1, ifid_flush=1, idex_bubble=1.
  3. hz_stall: pc_we=0, ifid_we=0, idex_bubble=1. The fetched word, if any, is dropped and refetched.
  4. imem_ready: pc_we=1, pc_sel=SEQ, ifid_we=1.
  5. Otherwise: ifid_we=1, ifid_flush=1; wait_cnt increments.
- Transitions out of S_RUN and wait_cnt rules:
  - Cases 1 and 2 with imem_ready=0 go to S_DRAIN, because the outstanding fetch must be discarded. With imem_ready=1 they stay in S_RUN.
  - wait_cnt clears on imem_ready or on any state exit.
  - wait_cnt==TIMEOUT-1 in case 5 goes to S_ERR.
  - wait_cnt is held in case 3.
- S_DRAIN:
  - imem_req=0, ifid_we=1, ifid_flush=1, idex_bubble=0.
  - On imem_ready, the word is discarded and the next state is S_RUN.
  - pc_ext_req is still honoured (pc_we=1, pc_sel=EXT) and the block stays in S_DRAIN.
  - br_resolve is a protocol violation and is ignored.
  - No timeout in S_DRAIN.
- S_ERR:
  - fetch_err=1; all other outputs 0.
  - Only reset exits S_ERR.
- uncond_sel is 0 whenever pc_sel≠BR.
- A reset asserted mid-DRAIN or mid-wait discards everything with no residual request.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs perf_fetch, perf_redirect and perf_stall (each PERF_W bits):
  - perf_fetch counts S_RUN cycles with pc_sel=SEQ and pc_we=1.
  - perf_redirect counts cycles with pc_sel=BR or EXT and pc_we=1.
  - perf_stall counts hz_stall-won cycles.
  - All three clear on reset and wrap modulo 2^PERF_W.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_seq_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {S_BOOT, S_RUN, S_DRAIN, S_ERR}.
  - typedef enum logic [1:0] pc_sel_t {PC_SEQ=0, PC_BR=1, PC_EXT=2}.
- One sub-module, event_counter (parameter W; inputs clk, reset, inc; output count). It is used for the three perf counters and is reused for boot_cnt with a clear input.

Test Plan:
1. Reset boot: reset=0 for 2 cycles then 1, imem_ready=1, BOOT_CYCLES=4 -> outputs 0 for 4 cycles, then imem_req=1, pc_we=1, pc_sel=0 every cycle.
2. Taken branch: in S_RUN, br_resolve=1, br_taken=1, br_uncond=1, imem_ready=1 -> the same cycle gives pc_sel=1, uncond_sel=1, ifid_flush=1, idex_bubble=1; state stays S_RUN.
3. Redirect during memory wait: imem_ready=0, br_taken with br_uncond=0 -> pc_sel=1, uncond_sel=0, then S_DRAIN with imem_req=0. imem_ready=1 after 3 cycles -> flushed NOP, then S_RUN on the next cycle.
4. Priority: pc_ext_req, br_taken and hz_stall all asserted together -> pc_sel=2, pc_we=1, idex_bubble=0.
5. Timeout: imem_ready held 0 for 16 cycles in S_RUN -> fetch_err=1 from cycle 17 and stays high through 10 further cycles with imem_ready=1; reset clears it.
6. With FETCH_PERF_EN: 10 sequential fetches, 2 branches and 3 stalls -> perf_fetch=10, perf_redirect=2, perf_stall=3.
